// File: rtl/adc_scan_sequencer.sv
// ADC scan sequencer: time-shares the on-die ADC across up to eight sense
// sources, visiting enabled sources round-robin and emitting one averaged
// result (2^AVG_LOG2 conversions) per visit.
//
// Handshakes:
//   ADC side   - adc_req is a one-cycle request pulse. Exactly one conversion is
//                in flight per pulse. It completes on the rising edge of the
//                adc_rdy level, and adc_value is captured on the cycle that edge
//                is seen. Edges that arrive while no request is outstanding are
//                ignored.
//   Result     - result_valid is a one-cycle push with no back-pressure.
//                result_chan and result_data are qualified by it and hold until
//                the next push.
module adc_scan_sequencer #(
   parameter int unsigned AVG_LOG2       = 2,
   parameter int unsigned SETTLE_CYCLES  = 32,
   parameter int unsigned TIMEOUT_CYCLES = 8192,
   parameter logic        ADC_MODE       = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [7:0]  chan_mask,
   output logic        adc_en,
   output logic        adc_req,
   output logic [2:0]  adc_vsenctl,
   output logic        adc_mode,
   input  logic        adc_rdy,
   input  logic [13:0] adc_value,
   output logic        result_valid,
   output logic [2:0]  result_chan,
   output logic [13:0] result_data,
   output logic        busy,
   output logic        timeout_err
);

   localparam int          ACC_W        = 14 + AVG_LOG2;
   localparam logic [4:0]  AVG_N        = 5'(1 << AVG_LOG2);
   localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SELECT = 3'd1,
      S_SETTLE = 3'd2,
      S_REQ    = 3'd3,
      S_WAIT   = 3'd4,
      S_ACCUM  = 3'd5,
      S_OUTPUT = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         last_chan_q, last_chan_d;
   logic [2:0]         vsenctl_q, vsenctl_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [4:0]         sample_cnt_q, sample_cnt_d;
   logic [15:0]        settle_cnt_q, settle_cnt_d;
   logic [15:0]        tmo_cnt_q, tmo_cnt_d;
   logic               adc_rdy_q, adc_rdy_d;
   logic               timeout_err_q, timeout_err_d;
   logic               result_valid_q, result_valid_d;
   logic [2:0]         result_chan_q, result_chan_d;
   logic [13:0]        result_data_q, result_data_d;

   logic               rdy_rise;
   logic [2:0]         next_chan;
   logic [2:0]         cand;
   logic               next_found;

   assign rdy_rise = adc_rdy & ~adc_rdy_q;

   // Round-robin pick: first enabled source after last_chan, wrapping 7->0.
   // The eighth candidate is last_chan itself, so a lone enabled source is
   // picked again.
   always_comb begin
      next_chan  = last_chan_q;
      next_found = 1'b0;
      cand       = 3'd0;
      for (int i = 1; i <= 8; i++) begin
         cand = last_chan_q + 3'(i);
         if (!next_found && chan_mask[cand]) begin
            next_chan  = cand;
            next_found = 1'b1;
         end
      end
   end

   // Next-state and datapath updates for the scan FSM.
   always_comb begin
      state_d        = state_q;
      last_chan_d    = last_chan_q;
      vsenctl_d      = vsenctl_q;
      acc_d          = acc_q;
      sample_cnt_d   = sample_cnt_q;
      settle_cnt_d   = settle_cnt_q;
      tmo_cnt_d      = tmo_cnt_q;
      adc_rdy_d      = adc_rdy;
      timeout_err_d  = timeout_err_q;
      result_valid_d = 1'b0;
      result_chan_d  = result_chan_q;
      result_data_d  = result_data_q;

      case (state_q)
         S_IDLE: begin
            if (enable && (chan_mask != 8'd0)) begin
               state_d = S_SELECT;
            end
         end

         S_SELECT: begin
            if (!enable || (chan_mask == 8'd0)) begin
               state_d = S_IDLE;
            end else begin
               vsenctl_d    = next_chan;
               last_chan_d  = next_chan;
               acc_d        = '0;
               sample_cnt_d = 5'd0;
               settle_cnt_d = 16'd0;
               state_d      = S_SETTLE;
            end
         end

         // Settling happens once per visit; later samples skip straight to REQ.
         S_SETTLE: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (settle_cnt_q == SETTLE_LAST) begin
               state_d = S_REQ;
            end else begin
               settle_cnt_d = settle_cnt_q + 16'd1;
            end
         end

         // A request already committed to is carried through even if enable
         // drops; the decision to stop is taken in ACCUM or on timeout.
         S_REQ: begin
            tmo_cnt_d = 16'd0;
            state_d   = S_WAIT;
         end

         // A ready edge beats a timeout landing on the same cycle.
         S_WAIT: begin
            if (rdy_rise) begin
               acc_d   = acc_q + ACC_W'(adc_value);
               state_d = S_ACCUM;
            end else if (tmo_cnt_q == TIMEOUT_LAST) begin
               timeout_err_d = 1'b1;
               state_d       = enable ? S_SELECT : S_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end

         S_ACCUM: begin
            sample_cnt_d = sample_cnt_q + 5'd1;
            if (!enable) begin
               state_d = S_IDLE;
            end else if (sample_cnt_d == AVG_N) begin
               state_d = S_OUTPUT;
            end else begin
               state_d = S_REQ;
            end
         end

         S_OUTPUT: begin
            result_valid_d = 1'b1;
            result_chan_d  = vsenctl_q;
            result_data_d  = 14'(acc_q >> AVG_LOG2);
            state_d        = enable ? S_SELECT : S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; last_chan starts at 7 so the first scan
   // begins with source 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         last_chan_q    <= 3'd7;
         vsenctl_q      <= 3'd0;
         acc_q          <= '0;
         sample_cnt_q   <= 5'd0;
         settle_cnt_q   <= 16'd0;
         tmo_cnt_q      <= 16'd0;
         adc_rdy_q      <= 1'b0;
         timeout_err_q  <= 1'b0;
         result_valid_q <= 1'b0;
         result_chan_q  <= 3'd0;
         result_data_q  <= 14'd0;
      end else begin
         state_q        <= state_d;
         last_chan_q    <= last_chan_d;
         vsenctl_q      <= vsenctl_d;
         acc_q          <= acc_d;
         sample_cnt_q   <= sample_cnt_d;
         settle_cnt_q   <= settle_cnt_d;
         tmo_cnt_q      <= tmo_cnt_d;
         adc_rdy_q      <= adc_rdy_d;
         timeout_err_q  <= timeout_err_d;
         result_valid_q <= result_valid_d;
         result_chan_q  <= result_chan_d;
         result_data_q  <= result_data_d;
      end
   end

   assign adc_en       = (state_q != S_IDLE);
   assign busy         = (state_q != S_IDLE);
   assign adc_req      = (state_q == S_REQ);
   assign adc_vsenctl  = vsenctl_q;
   assign adc_mode     = ADC_MODE;
   assign result_valid = result_valid_q;
   assign result_chan  = result_chan_q;
   assign result_data  = result_data_q;
   assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Testbench for adc_scan_sequencer: behavioural ADC model, result monitor,
// table-driven scan vectors, hand-written corner sequences, randomized scans.
module tb_adc_scan_sequencer;

   localparam int AVG_LOG2 = 2;
   localparam int NSAMP    = 1 << AVG_LOG2;
   localparam int SETTLE   = 12;
   localparam int TIMEOUT  = 300;

   // ---------------- clock / reset / DUT ----------------
   logic        clk;
   logic        rst;
   logic        enable;
   logic [7:0]  chan_mask;
   logic        adc_en;
   logic        adc_req;
   logic [2:0]  adc_vsenctl;
   logic        adc_mode;
   logic        adc_rdy;
   logic [13:0] adc_value;
   logic        result_valid;
   logic [2:0]  result_chan;
   logic [13:0] result_data;
   logic        busy;
   logic        timeout_err;

   logic        model_rdy;
   logic [13:0] model_val;
   logic        man_rdy;
   logic [13:0] man_val;
   logic [7:0]  dead_mask;
   logic        rand_mode;

   assign adc_rdy   = model_rdy | man_rdy;
   assign adc_value = man_rdy ? man_val : model_val;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   adc_scan_sequencer #(
      .AVG_LOG2       (AVG_LOG2),
      .SETTLE_CYCLES  (SETTLE),
      .TIMEOUT_CYCLES (TIMEOUT),
      .ADC_MODE       (1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .chan_mask    (chan_mask),
      .adc_en       (adc_en),
      .adc_req      (adc_req),
      .adc_vsenctl  (adc_vsenctl),
      .adc_mode     (adc_mode),
      .adc_rdy      (adc_rdy),
      .adc_value    (adc_value),
      .result_valid (result_valid),
      .result_chan  (result_chan),
      .result_data  (result_data),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   // ---------------- reference model ----------------
   // Round-robin rule: first enabled source after 'last', wrapping 7->0.
   function automatic logic [2:0] rr_next(input logic [7:0] m, input logic [2:0] last);
      for (int d = 1; d <= 8; d++) begin
         int c;
         c = (int'(last) + d) % 8;
         if (m[c]) return 3'(c);
      end
      return last;
   endfunction

   // Behavioural ADC: answers each request after 1..5 cycles with a one-cycle
   // ready pulse. Sources in dead_mask never answer. Fixed mode returns
   // 100 + 50*ch + k*(ch+1) for the k-th sample of a visit; random mode returns
   // random codes and groups every NSAMP of them into one expected result.
   int unsigned k_cnt [8];
   logic [16:0] exp_q[$];
   int          grp_sum;
   int          grp_n;
   logic [2:0]  m_last;
   logic [2:0]  m_ch;
   int          left;
   logic        pend;

   initial begin
      int v;
      model_rdy = 1'b0;
      model_val = 14'd0;
      pend      = 1'b0;
      grp_sum   = 0;
      grp_n     = 0;
      m_last    = 3'd7;
      m_ch      = 3'd0;
      left      = 0;
      foreach (k_cnt[i]) k_cnt[i] = 0;
      forever begin
         @(posedge clk);
         #1;
         model_rdy = 1'b0;
         if (rst) begin
            pend    = 1'b0;
            grp_sum = 0;
            grp_n   = 0;
            m_last  = 3'd7;
            exp_q.delete();
            foreach (k_cnt[i]) k_cnt[i] = 0;
         end else if (pend) begin
            if (left > 1) begin
               left = left - 1;
            end else begin
               pend = 1'b0;
               if (rand_mode) begin
                  v = int'($urandom_range(0, 16383));
               end else begin
                  v = 100 + 50 * int'(m_ch) + int'(k_cnt[m_ch]) * (int'(m_ch) + 1);
                  k_cnt[m_ch] = (k_cnt[m_ch] + 1) % NSAMP;
               end
               model_val = 14'(v);
               model_rdy = 1'b1;
               if (rand_mode) begin
                  grp_sum = grp_sum + v;
                  grp_n   = grp_n + 1;
                  if (grp_n == NSAMP) begin
                     m_last = rr_next(chan_mask, m_last);
                     exp_q.push_back({m_last, 14'(grp_sum / NSAMP)});
                     grp_sum = 0;
                     grp_n   = 0;
                  end
               end
            end
         end else if (adc_req && !dead_mask[adc_vsenctl]) begin
            pend = 1'b1;
            m_ch = adc_vsenctl;
            left = int'($urandom_range(1, 5));
         end
      end
   end

   // ---------------- monitor ----------------
   logic [16:0] got_q[$];
   int          reqn_q[$];
   int          gap_q[$];
   int          cyc;
   int          total_req;
   int          reqs_since;
   int          rv_cyc;
   int          last_req_cyc;
   int          err_gap;
   logic        gap_armed;
   logic        err_seen;

   initial begin
      cyc = 0; total_req = 0; reqs_since = 0; rv_cyc = 0;
      last_req_cyc = 0; err_gap = -1; gap_armed = 1'b0; err_seen = 1'b0;
      forever begin
         @(negedge clk);
         cyc = cyc + 1;
         if (rst) begin
            got_q.delete(); reqn_q.delete(); gap_q.delete();
            total_req = 0; reqs_since = 0; err_gap = -1;
            gap_armed = 1'b0; err_seen = 1'b0;
         end else begin
            if (adc_req) begin
               total_req    = total_req + 1;
               reqs_since   = reqs_since + 1;
               last_req_cyc = cyc;
               if (gap_armed) begin
                  gap_q.push_back(cyc - rv_cyc);
                  gap_armed = 1'b0;
               end
            end
            if (timeout_err && !err_seen) begin
               err_seen = 1'b1;
               err_gap  = cyc - last_req_cyc;
            end
            if (result_valid) begin
               got_q.push_back({result_chan, result_data});
               reqn_q.push_back(reqs_since);
               reqs_since = 0;
               rv_cyc     = cyc;
               gap_armed  = 1'b1;
            end
         end
      end
   end

   function automatic logic [16:0] got_at(input int i);
      if (i < got_q.size()) return got_q[i];
      return '1;
   endfunction

   function automatic logic [16:0] exp_at(input int i);
      if (i < exp_q.size()) return exp_q[i];
      return '0;
   endfunction

   function automatic int reqn_at(input int i);
      if (i < reqn_q.size()) return reqn_q[i];
      return -1;
   endfunction

   function automatic int gap_at(input int i);
      if (i < gap_q.size()) return gap_q[i];
      return -1;
   endfunction

   // ---------------- scoreboard / checks ----------------
   int total;
   int bad;

   task automatic check(input string name, input int act, input int exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_ctl"}, int'({adc_en, adc_req, adc_vsenctl, busy, timeout_err}), 0);
      check({name, "_res"}, int'({result_valid, result_chan, result_data}), 0);
      check({name, "_mode"}, int'(adc_mode), 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst    = 1'b1;
      enable = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
   endtask

   task automatic wait_results(input int n, input int budget, input string name);
      int t;
      t = 0;
      while (got_q.size() < n && t < budget) begin
         @(negedge clk);
         #2;
         t = t + 1;
      end
      check({name, "_result_count"}, int'(got_q.size() >= n), 1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0]  mask;
      logic [2:0]  chan [3];
      logic [13:0] data [3];
   } vec_t;

   vec_t vecs [4];

   task automatic set_vec(input int i, input logic [7:0] m,
                          input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2,
                          input logic [13:0] d0, input logic [13:0] d1, input logic [13:0] d2);
      vecs[i].mask    = m;
      vecs[i].chan[0] = c0; vecs[i].chan[1] = c1; vecs[i].chan[2] = c2;
      vecs[i].data[0] = d0; vecs[i].data[1] = d1; vecs[i].data[2] = d2;
   endtask

   // ---------------- main test ----------------
   initial begin
      logic [16:0] g;
      int          t;
      int          hi;

      total = 0; bad = 0;
      rst = 1'b1; enable = 1'b0; chan_mask = 8'd0;
      man_rdy = 1'b0; man_val = 14'd0; dead_mask = 8'd0; rand_mode = 1'b0;

      // Fixed ADC averages: ch0 101, ch1 153, ch2 204, ch4 307, ch6 410, ch7 462.
      set_vec(0, 8'h05, 3'd0, 3'd2, 3'd0, 14'd101, 14'd204, 14'd101);
      set_vec(1, 8'h80, 3'd7, 3'd7, 3'd7, 14'd462, 14'd462, 14'd462);
      set_vec(2, 8'h12, 3'd1, 3'd4, 3'd1, 14'd153, 14'd307, 14'd153);
      set_vec(3, 8'hC1, 3'd0, 3'd6, 3'd7, 14'd101, 14'd410, 14'd462);

      repeat (3) @(negedge clk);

      // Table-driven scans from reset.
      for (int v = 0; v < 4; v++) begin
         do_reset();
         chan_mask = vecs[v].mask;
         enable    = 1'b1;
         wait_results(3, 800, $sformatf("v%0d", v));
         for (int r = 0; r < 3; r++) begin
            g = got_at(r);
            check($sformatf("v%0d_r%0d_chan", v, r), int'(g[16:14]), int'(vecs[v].chan[r]));
            check($sformatf("v%0d_r%0d_data", v, r), int'(g[13:0]), int'(vecs[v].data[r]));
            check($sformatf("v%0d_r%0d_reqs", v, r), reqn_at(r), NSAMP);
            if (r > 0) check($sformatf("v%0d_r%0d_settle_gap", v, r), gap_at(r - 1), SETTLE + 1);
         end
      end

      // Source 3 never answers: timeout after TIMEOUT cycles in WAIT, no result for it.
      do_reset();
      dead_mask = 8'h08;
      chan_mask = 8'h0A;
      enable    = 1'b1;
      wait_results(2, 2000, "tmo");
      check("tmo_r0", int'(got_at(0)), int'({3'd1, 14'd153}));
      check("tmo_r1", int'(got_at(1)), int'({3'd1, 14'd153}));
      check("tmo_req_to_err", err_gap, TIMEOUT + 1);
      check("tmo_err_sticky", int'(timeout_err), 1);

      // Enable dropped while waiting on the third sample of source 2.
      do_reset();
      dead_mask = 8'h00;
      chan_mask = 8'h05;
      enable    = 1'b1;
      wait_results(1, 300, "edrop_first");
      t = 0;
      while (reqs_since < 3 && t < 300) begin
         @(negedge clk);
         #2;
         t = t + 1;
      end
      check("edrop_third_req", int'(reqs_since == 3), 1);
      enable = 1'b0;
      t = 0;
      do begin
         @(negedge clk);
         t = t + 1;
      end while (!adc_rdy && t < 50);
      check("edrop_rdy_seen", int'(adc_rdy), 1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("edrop_busy", int'(busy), 0);
      check("edrop_adc_en", int'(adc_en), 0);
      repeat (60) @(negedge clk);
      check("edrop_no_result", got_q.size(), 1);
      check("edrop_stays_idle", int'(busy), 0);

      // Empty mask with enable high: never leaves IDLE.
      do_reset();
      chan_mask = 8'h00;
      enable    = 1'b1;
      hi = 0;
      repeat (1000) begin
         @(negedge clk);
         if (adc_en || busy || adc_req) hi = hi + 1;
      end
      check("mask0_active_cycles", hi, 0);
      check("mask0_reqs", total_req, 0);

      // Reset while waiting on a conversion, then a stray ready edge.
      do_reset();
      dead_mask = 8'h01;
      chan_mask = 8'h05;
      enable    = 1'b1;
      t = 0;
      while (total_req < 1 && t < 100) begin
         @(negedge clk);
         #2;
         t = t + 1;
      end
      check("rstw_req_seen", int'(total_req >= 1), 1);
      repeat (5) @(negedge clk);
      check("rstw_busy_before", int'(busy), 1);
      rst       = 1'b1;
      dead_mask = 8'h00;
      #1;
      check_reset_outputs("rstw");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      man_val = 14'h3FFF;
      man_rdy = 1'b1;
      repeat (2) @(negedge clk);
      man_rdy = 1'b0;
      wait_results(1, 300, "rstw_restart");
      check("rstw_first_result", int'(got_at(0)), int'({3'd0, 14'd101}));
      check("rstw_first_reqs", reqn_at(0), NSAMP);

      // Randomized masks and ADC codes against the reference model.
      for (int r = 0; r < 3; r++) begin
         do_reset();
         rand_mode = 1'b1;
         chan_mask = 8'($urandom_range(1, 255));
         enable    = 1'b1;
         wait_results(6, 1500, $sformatf("rnd%0d", r));
         for (int i = 0; i < 6; i++) begin
            check($sformatf("rnd%0d_mask%0h_r%0d", r, chan_mask, i), int'(got_at(i)), int'(exp_at(i)));
         end
      end
      rand_mode = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Owns the on-die ADC hard macro and time-shares it across up to 8 sense sources (VSENCTL codes 0-7).
- Scans the enabled sources round-robin and averages 2^AVG_LOG2 conversions per source.
- Emits one averaged result per source visit to the housekeeping/telemetry logic.
- Sits between the ADC wrapper and system monitoring (battery, temperature, supply rails).

Parameters:
- AVG_LOG2, 2, log2 of conversions averaged per source; legal range 0..4.
- SETTLE_CYCLES, 32, clk cycles to wait after changing vsenctl before requesting a conversion; legal range 1..65535.
- TIMEOUT_CYCLES, 8192, max clk cycles in WAIT before abandoning a conversion; legal range 1..65535.
- ADC_MODE, 1, constant driven onto adc_mode.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  level; scanning runs while high.
- chan_mask  in  8  bit n=1 enables source n; sampled only in SELECT.
- adc_en  out  1  ADC enable.
- adc_req  out  1  conversion request pulse.
- adc_vsenctl  out  3  source select to ADC.
- adc_mode  out  1  equals ADC_MODE.
- adc_rdy  in  1  ADC ready level; conversion complete on its rising edge.
- adc_value  in  14  ADC result; valid when adc_rdy rises.
- result_valid  out  1  one-cycle pulse.
- result_chan  out  3  source of the result.
- result_data  out  14  averaged value.
- busy  out  1  high when state != IDLE.
- timeout_err  out  1  sticky; cleared only by rst.

Behaviour:
- Reset values: adc_en=0, adc_req=0, adc_vsenctl=0, result_valid=0, result_chan=0, result_data=0, busy=0, timeout_err=0. Internal state: state=IDLE, last_chan=7, so the first scan starts at source 0. adc_mode is constant.
- adc_rdy is registered once internally. rdy_rise = adc_rdy & ~adc_rdy_q.
- FSM states: IDLE, SELECT, SETTLE, REQ, WAIT, ACCUM, OUTPUT.
- IDLE:
  - If enable=1 and chan_mask!=0, go to SELECT.
  - If chan_mask=0, remain in IDLE.
- SELECT (1 cycle):
  - next = first set bit of chan_mask searching from last_chan+1, wrapping 7->0. If only one bit is set, the same source is reselected.
  - Load adc_vsenctl=next and last_chan=next; clear accumulator and sample count; go to SETTLE.
  - If chan_mask has become 0, go to IDLE.
- SETTLE: counter runs SETTLE_CYCLES cycles, then go to REQ. Settling is applied once per source visit, not per sample.
- REQ: adc_req=1 for exactly this one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - On rdy_rise: accumulate adc_value and go to ACCUM.
  - If the timeout counter reaches TIMEOUT_CYCLES first: set timeout_err, discard the partial accumulator, emit no result, go to SELECT (next source).
  - If rdy_rise and timeout occur in the same cycle, rdy_rise wins.
  - A rdy_rise outside WAIT is ignored.
- ACCUM:
  - Accumulator width 14+AVG_LOG2; sample count is incremented.
  - If count == 2^AVG_LOG2, go to OUTPUT; otherwise go to REQ (no re-settle).
- OUTPUT (1 cycle):
  - result_data = accumulator >> AVG_LOG2 (truncating).
  - result_chan = adc_vsenctl; result_valid=1.
  - Go to SELECT if enable=1, else IDLE.
- Latency per source visit: 1 (SELECT) + SETTLE_CYCLES + per sample [1 REQ + ADC conversion time + 1 edge-detect + 1 ACCUM] + 1 OUTPUT.
- result_valid high one cycle at OUTPUT exit; result_chan/result_data hold until the next OUTPUT.
- enable deassert:
  - In SELECT or SETTLE: go to IDLE at the next edge.
  - In REQ, WAIT or ACCUM: the in-flight conversion completes or times out, then go to IDLE with no result; the partial average is discarded.
  - In OUTPUT: the result is still emitted.
- adc_en = 1 in every state except IDLE. adc_vsenctl holds its last value in IDLE.
- rst mid-conversion: all outputs return to reset values immediately; any later adc_rdy edge is ignored until the next REQ.

Test Plan:
- rst, enable=1, chan_mask=8'b0000_0101, AVG_LOG2=2, ADC model returns 100,101,102,103 then 200,200,200,200 -> result (chan 0, data 101), then (chan 2, data 200), then chan 0 again; adc_req exactly 4 pulses per source; SETTLE_CYCLES gap after each vsenctl change.
- chan_mask=8'b1000_0000, single source -> repeated results all with result_chan=7; vsenctl stays 7; settle still inserted each visit.
- ADC model never raises adc_rdy for source 3, mask=8'b0000_1010 -> timeout_err=1 after exactly TIMEOUT_CYCLES in WAIT; no result for chan 3; scanning continues with chan 1 results.
- enable dropped mid-WAIT on the 3rd sample -> conversion completes, no result_valid, busy falls within 2 cycles of rdy_rise, adc_en=0.
- chan_mask=0 with enable=1 -> stays IDLE, adc_en=0, no adc_req for 1000 cycles.
- Assert rst during WAIT, then release and raise adc_rdy -> no accumulation, no result; outputs at reset values; the scan restarts at source 0.
